// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: FSM encoding, BCD digit limits
// and the field layout of the packed display word.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] LIMIT_9 = 4'd9;
  localparam logic [DIGIT_W-1:0] LIMIT_5 = 4'd5;

  // Bit offsets of each digit inside disp_bcd = {min_t, min_o, sec_t, sec_o, cs_t, cs_o}
  localparam int CS_O_LSB  = 0;
  localparam int CS_T_LSB  = 4;
  localparam int SEC_O_LSB = 8;
  localparam int SEC_T_LSB = 12;
  localparam int MIN_O_LSB = 16;
  localparam int MIN_T_LSB = 20;

endpackage

// File: rtl/stopwatch_core_if.sv
// Signal bundle between the timebase/button stages and the stopwatch core,
// plus the display-side outputs and a debug view of the control FSM.
interface stopwatch_core_if;
  // tick_ms, start_stop and clear_lap are single-cycle strobes sampled on the
  // rising clk edge; there is no backpressure, every high cycle is acted on.
  logic        tick_ms;
  logic        start_stop;
  logic        clear_lap;
  logic [23:0] disp_bcd;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic [1:0]  state_dbg;

  modport master (
    output tick_ms, start_stop, clear_lap,
    input  disp_bcd, running, lap_active, overflow, state_dbg
  );

  modport slave (
    input  tick_ms, start_stop, clear_lap,
    output disp_bcd, running, lap_active, overflow, state_dbg
  );
endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..LIMIT with synchronous clear, a carry-in
// increment and a combinational carry-out on wrap.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] LIMIT = LIMIT_9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;
  logic               at_limit;

  // >= rather than == so a corrupted digit still falls back into range
  assign at_limit = (q_q >= LIMIT);
  assign carry    = inc & at_limit & ~clr;
  assign q        = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = at_limit ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS.CC stopwatch in packed BCD, advanced by a 1 kHz tick through a
// centisecond prescaler, with start/pause/resume, clear and lap freeze.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_CS = 10,
  parameter int MAX_MIN      = 59
) (
  input  logic             clk,
  input  logic             reset_n,
  stopwatch_core_if.slave  sw
);

  localparam logic [7:0]         PRESC_LAST = 8'(TICKS_PER_CS - 1);
  localparam logic [DIGIT_W-1:0] MAX_MIN_T  = DIGIT_W'(MAX_MIN / 10);
  localparam logic [DIGIT_W-1:0] MAX_MIN_O  = DIGIT_W'(MAX_MIN % 10);

  sw_state_e          state_q, state_d;
  logic               lap_active_q, lap_active_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         presc_q, presc_d;
  logic [23:0]        lap_q, lap_d;
  logic [DIGIT_W-1:0] min_t_q, min_t_d;
  logic [DIGIT_W-1:0] min_o_q, min_o_d;

  logic               lap_load;
  logic               clr_time;
  logic               cnt_en;
  logic               cs_inc;
  logic               min_wrap;
  logic [DIGIT_W-1:0] cs_o, cs_t, sec_o, sec_t;
  logic               cs_o_cy, cs_t_cy, sec_o_cy, sec_t_cy;
  logic [23:0]        time_bcd;

  // Control FSM; start_stop has priority over clear_lap in every state
  always_comb begin
    state_d      = state_q;
    lap_active_d = lap_active_q;
    lap_load     = 1'b0;
    clr_time     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sw.start_stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sw.start_stop) begin
          state_d = ST_PAUSE;
        end else if (sw.clear_lap) begin
          lap_active_d = ~lap_active_q;
          lap_load     = ~lap_active_q;
        end
      end
      ST_PAUSE: begin
        if (sw.start_stop) begin
          state_d = ST_RUN;
        end else if (sw.clear_lap) begin
          state_d      = ST_IDLE;
          clr_time     = 1'b1;
          lap_active_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        clr_time     = 1'b1;
        lap_active_d = 1'b0;
      end
    endcase
  end

  // Based on the current state, so the tick that enters RUN is ignored and
  // the tick that leaves RUN still counts.
  assign cnt_en = (state_q == ST_RUN) & sw.tick_ms;
  assign cs_inc = cnt_en & (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr_time) begin
      presc_d = '0;
    end else if (cnt_en) begin
      presc_d = (presc_q == PRESC_LAST) ? 8'd0 : presc_q + 8'd1;
    end
  end

  bcd_digit_counter #(.LIMIT(LIMIT_9)) u_cs_o (
    .clk(clk), .reset_n(reset_n), .clr(clr_time), .inc(cs_inc),
    .q(cs_o), .carry(cs_o_cy)
  );

  bcd_digit_counter #(.LIMIT(LIMIT_9)) u_cs_t (
    .clk(clk), .reset_n(reset_n), .clr(clr_time), .inc(cs_o_cy),
    .q(cs_t), .carry(cs_t_cy)
  );

  bcd_digit_counter #(.LIMIT(LIMIT_9)) u_sec_o (
    .clk(clk), .reset_n(reset_n), .clr(clr_time), .inc(cs_t_cy),
    .q(sec_o), .carry(sec_o_cy)
  );

  bcd_digit_counter #(.LIMIT(LIMIT_5)) u_sec_t (
    .clk(clk), .reset_n(reset_n), .clr(clr_time), .inc(sec_o_cy),
    .q(sec_t), .carry(sec_t_cy)
  );

  // Minute pair counts 00..MAX_MIN as a unit; rolling past the top is the wrap
  always_comb begin
    min_t_d  = min_t_q;
    min_o_d  = min_o_q;
    min_wrap = 1'b0;
    if (clr_time) begin
      min_t_d = '0;
      min_o_d = '0;
    end else if (sec_t_cy) begin
      if ((min_t_q == MAX_MIN_T) && (min_o_q == MAX_MIN_O)) begin
        min_t_d  = '0;
        min_o_d  = '0;
        min_wrap = 1'b1;
      end else if (min_o_q >= LIMIT_9) begin
        min_o_d = '0;
        min_t_d = min_t_q + 1'b1;
      end else begin
        min_o_d = min_o_q + 1'b1;
      end
    end
  end

  assign time_bcd = {min_t_q, min_o_q, sec_t, sec_o, cs_t, cs_o};

  always_comb begin
    overflow_d = overflow_q;
    if (clr_time) begin
      overflow_d = 1'b0;
    end else if (min_wrap) begin
      overflow_d = 1'b1;
    end
  end

  assign lap_d = lap_load ? time_bcd : lap_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      presc_q      <= '0;
      lap_q        <= '0;
      min_t_q      <= '0;
      min_o_q      <= '0;
    end else begin
      state_q      <= state_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
      presc_q      <= presc_d;
      lap_q        <= lap_d;
      min_t_q      <= min_t_d;
      min_o_q      <= min_o_d;
    end
  end

  assign sw.disp_bcd   = lap_active_q ? lap_q : time_bcd;
  assign sw.running    = (state_q == ST_RUN);
  assign sw.lap_active = lap_active_q;
  assign sw.overflow   = overflow_q;
  assign sw.state_dbg  = state_q;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Downstream consumer of the clock-divider counters: takes the 1 kHz tick pulse (one-cycle strobe decoded at the wrap of the 17-bit divide-by-100000 counter) and runs an MM:SS.CC stopwatch in packed BCD.
- Start/stop and clear/lap command pulses come from the debounced button stage.
- Drives the 7-segment display mux directly.

Parameters:
- TICKS_PER_CS, 10, tick_ms pulses per centisecond increment (legal 1..255).
- MAX_MIN, 59, highest minute value before wrap to 00:00.00 (legal 1..99).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- tick_ms  input  1  one-cycle 1 kHz timebase strobe
- start_stop  input  1  one-cycle command pulse: start/pause/resume
- clear_lap  input  1  one-cycle command pulse: clear when not running, lap toggle when running
- disp_bcd  output  24  {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, 4 bits each, displayed time
- running  output  1  high in RUN state
- lap_active  output  1  high while display is frozen on a lap value
- overflow  output  1  sticky: time wrapped past MAX_MIN:59.99

Behaviour:
- Reset and interface:
  - One clock, clk.
  - Reset is asynchronous, active-low, on reset_n; all state clears immediately on assertion.
  - Reset state: IDLE, time = 00:00.00, prescaler = 0, lap register = 0.
  - Reset outputs: disp_bcd = 24'h000000, running = 0, lap_active = 0, overflow = 0.
- States:
  - IDLE: time zero, prescaler zero.
  - RUN: counting.
  - PAUSE: time and prescaler held.
- Transitions:
  - IDLE + start_stop -> RUN.
  - RUN + start_stop -> PAUSE.
  - PAUSE + start_stop -> RUN.
  - PAUSE + clear_lap -> IDLE: time, prescaler and overflow cleared.
  - IDLE + clear_lap: no effect.
- Lap:
  - RUN + clear_lap with lap_active=0: copy current time into lap register, set lap_active.
  - RUN + clear_lap with lap_active=1: release lap, clear lap_active.
  - Counting continues underneath the frozen display.
  - Entering PAUSE keeps lap_active; PAUSE -> IDLE clears it.
- Simultaneous start_stop and clear_lap in the same cycle: start_stop acts, clear_lap is ignored.
- Prescaler (8 bit):
  - Increments only in RUN on cycles with tick_ms=1.
  - When it equals TICKS_PER_CS-1 with tick_ms=1: reset to 0, increment time by one centisecond at that same edge.
  - Latency tick -> disp_bcd change is 1 clock (registered time, combinational output mux).
  - A tick_ms coinciding with the start_stop that enters RUN is not counted.
  - A tick_ms coinciding with the start_stop that leaves RUN is counted.
- BCD arithmetic, each digit a registered counter with carry-in and carry-out:
  - cs_o 0-9 carries into cs_t 0-9.
  - cs_t carries into sec_o 0-9.
  - sec_o carries into sec_t 0-5.
  - sec_t carries into the minute pair, 00..MAX_MIN.
  - Carry is combinational within the one increment cycle.
  - Digits never hold non-BCD values.
- Wrap: increment at MAX_MIN:59.99 -> 00:00.00, overflow set (sticky until PAUSE->IDLE clear or reset), counting continues.
- Outputs:
  - disp_bcd = lap register when lap_active, otherwise time register.
  - running = (state == RUN).
- tick_ms held high for multiple cycles: each high cycle counts as a tick; upstream guarantees single-cycle strobes.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2
  - BCD digit width constant (4)
  - digit limit constants (9, 5)
  - disp_bcd field offsets
- One natural sub-module, bcd_digit_counter.
  - Parameters: LIMIT.
  - Ports: clk, reset_n, clr, inc, q[3:0], carry.
  - Instantiated for cs_o, cs_t, sec_o, sec_t.
- The minute pair uses a small two-digit block against MAX_MIN, in-line.

Test Plan:
1. Reset and first count (TICKS_PER_CS=2, tick_ms every 4 clocks):
   - Assert reset_n=0 mid-count -> all outputs 0 immediately.
   - Release, pulse start_stop -> running=1.
   - After 20 ticks -> disp_bcd = 24'h000010.
2. Carry chain:
   - Run to 00:09.99, one more centisecond -> 24'h001000.
   - From 00:59.99 -> 24'h010000.
   - Every intermediate digit is 0-9 (tens-of-seconds 0-5).
3. Pause/resume/clear:
   - start_stop at 00:00.37 -> running=0; further ticks leave disp_bcd=24'h000037.
   - start_stop again -> resumes from 37.
   - Pause, clear_lap -> IDLE, 24'h000000.
4. Lap:
   - In RUN at 00:01.50, clear_lap -> lap_active=1, disp_bcd frozen at 24'h000150 while 30 more cs elapse.
   - clear_lap again -> lap_active=0, disp_bcd=24'h000180.
5. Wrap and simultaneity:
   - MAX_MIN=1, run past 01:59.99 -> 24'h000000, overflow=1, still running.
   - start_stop and clear_lap in the same cycle in RUN -> PAUSE, lap_active unchanged.
   - Pause then clear -> overflow=0.
